// File: rtl/d_egress_arbiter.sv
// d_egress_arbiter: drains the two destination FIFOs round-robin into a single
// valid/ready stream tagged with its source, and counts delivered words per source.
module d_egress_arbiter #(
  parameter int BW    = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active_in,
  input  logic             error_in,
  input  logic             D0_empty,
  input  logic             D1_empty,
  input  logic [BW-1:0]    D0_data_out,
  input  logic [BW-1:0]    D1_data_out,
  output logic             D0_rd,
  output logic             D1_rd,
  output logic [BW-1:0]    out_data,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_D0,
  output logic [CNT_W-1:0] cnt_D1,
  output logic [1:0]       state_out,
  output logic             idle_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic          inflight;
  logic          inflight_src;
  logic          last_grant;
  logic [1:0]    occ;
  logic          rd_ptr;
  logic          wr_ptr;
  logic [BW-1:0] buf_data [0:1];
  logic          buf_src  [0:1];

  logic          push;
  logic          pop;
  logic [2:0]    credit_sum;
  logic          credit_ok;
  logic          elig0;
  logic          elig1;
  logic          issue;
  logic          grant_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (active_in) state_next = RUN;
      RUN: begin
        if (error_in)       state_next = ERROR;
        else if (!active_in) state_next = IDLE;
      end
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  assign push      = inflight;
  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = buf_data[rd_ptr];
  assign out_src   = buf_src[rd_ptr];

  // Count the landing read against the buffer now, so a stalled output never overflows it.
  assign credit_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign credit_ok  = (credit_sum < 3'd2);
  assign elig0      = !D0_empty;
  assign elig1      = !D1_empty;

  always_comb begin
    issue     = 1'b0;
    grant_src = 1'b0;
    if (state == RUN && credit_ok) begin
      if (elig0 && elig1) begin
        issue     = 1'b1;
        grant_src = ~last_grant;
      end else if (elig0) begin
        issue     = 1'b1;
        grant_src = 1'b0;
      end else if (elig1) begin
        issue     = 1'b1;
        grant_src = 1'b1;
      end
    end
  end

  assign D0_rd = issue & ~grant_src;
  assign D1_rd = issue & grant_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight     <= 1'b0;
      inflight_src <= 1'b0;
      last_grant   <= 1'b1;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_src <= grant_src;
        last_grant   <= grant_src;
      end
    end
  end

  // At full occupancy a push only coincides with a pop, so overwriting the head slot is safe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ         <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_src[0]  <= 1'b0;
      buf_src[1]  <= 1'b0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= inflight_src ? D1_data_out : D0_data_out;
        buf_src[wr_ptr]  <= inflight_src;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_D0 <= '0;
      cnt_D1 <= '0;
    end else if (pop) begin
      if (out_src) cnt_D1 <= cnt_D1 + CNT_W'(1);
      else         cnt_D0 <= cnt_D0 + CNT_W'(1);
    end
  end

  assign state_out = state;
  assign idle_out  = !inflight && (occ == 2'd0) && D0_empty && D1_empty;

endmodule

// File: tb/tb_d_egress_arbiter.sv
// Bench for d_egress_arbiter: queue-backed FIFO models feed the DUT and the
// delivered stream is compared with a round-robin interleave of what was loaded.
module tb_d_egress_arbiter;

  localparam int BW    = 6;
  localparam int CNT_W = 8;
  localparam int MEMD  = 4096;

  logic             clk = 1'b0;
  logic             reset;
  logic             active_in;
  logic             error_in;
  logic             D0_empty;
  logic             D1_empty;
  logic [BW-1:0]    D0_data_out = '0;
  logic [BW-1:0]    D1_data_out = '0;
  logic             D0_rd;
  logic             D1_rd;
  logic [BW-1:0]    out_data;
  logic             out_src;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] cnt_D0;
  logic [CNT_W-1:0] cnt_D1;
  logic [1:0]       state_out;
  logic             idle_out;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [BW-1:0] mem0 [0:MEMD-1];
  logic [BW-1:0] mem1 [0:MEMD-1];
  int            pushed0 = 0;
  int            pushed1 = 0;
  int            popped0 = 0;
  int            popped1 = 0;
  logic          flush = 1'b0;

  logic [BW-1:0] exp0 [$];
  logic [BW-1:0] exp1 [$];
  logic [BW:0]   exp_q [$];

  logic [BW:0]   rx_q [$];
  logic [1:0]    rd_hist [$];
  int            both_rd = 0;
  int            rd_bad  = 0;
  int            stab_err = 0;
  logic          prev_stall = 1'b0;
  logic [BW:0]   prev_word = '0;

  d_egress_arbiter #(.BW(BW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .active_in  (active_in),
    .error_in   (error_in),
    .D0_empty   (D0_empty),
    .D1_empty   (D1_empty),
    .D0_data_out(D0_data_out),
    .D1_data_out(D1_data_out),
    .D0_rd      (D0_rd),
    .D1_rd      (D1_rd),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cnt_D0     (cnt_D0),
    .cnt_D1     (cnt_D1),
    .state_out  (state_out),
    .idle_out   (idle_out)
  );

  always #5 clk = ~clk;

  assign D0_empty = (pushed0 == popped0);
  assign D1_empty = (pushed1 == popped1);

  // Destination FIFOs with registered read data: a pop at this edge shows its word next cycle.
  always @(posedge clk) begin
    if (flush) begin
      popped0 <= pushed0;
      popped1 <= pushed1;
    end else begin
      if (D0_rd && !D0_empty) begin
        D0_data_out <= mem0[popped0 % MEMD];
        popped0     <= popped0 + 1;
      end
      if (D1_rd && !D1_empty) begin
        D1_data_out <= mem1[popped1 % MEMD];
        popped1     <= popped1 + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      rd_hist.push_back({D1_rd, D0_rd});
      if (D0_rd && D1_rd) both_rd++;
      if ((D0_rd || D1_rd) && state_out != 2'd1) rd_bad++;
      if (prev_stall && (!out_valid || {out_src, out_data} !== prev_word)) stab_err++;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_src, out_data};
      if (out_valid && out_ready) rx_q.push_back({out_src, out_data});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push0(input logic [BW-1:0] d);
    mem0[pushed0 % MEMD] = d;
    pushed0 = pushed0 + 1;
    exp0.push_back(d);
  endtask

  task automatic push1(input logic [BW-1:0] d);
    mem1[pushed1 % MEMD] = d;
    pushed1 = pushed1 + 1;
    exp1.push_back(d);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    active_in = 1'b0;
    error_in  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b1;
    step(2);
    flush = 1'b0;
    exp0.delete();
    exp1.delete();
    reset = 1'b0;
  endtask

  // Round-robin from the spec's rules: D0 first after reset, alternate while both have data.
  function automatic void build_expect();
    int  i;
    int  j;
    bit  turn;
    i = 0;
    j = 0;
    turn = 1'b0;
    exp_q.delete();
    while (i < exp0.size() || j < exp1.size()) begin
      if (i < exp0.size() && (turn == 1'b0 || j >= exp1.size())) begin
        exp_q.push_back({1'b0, exp0[i]});
        i++;
        turn = 1'b1;
      end else begin
        exp_q.push_back({1'b1, exp1[j]});
        j++;
        turn = 1'b0;
      end
    end
  endfunction

  function automatic logic [BW:0] get_rx(input int idx);
    if (idx < rx_q.size()) return rx_q[idx];
    return 'x;
  endfunction

  task automatic test_reset();
    int rd_seen;
    reset = 1'b1;
    active_in = 1'b0;
    error_in  = 1'b0;
    out_ready = 1'b0;
    flush = 1'b1;
    step(2);
    flush = 1'b0;
    tests_run++;
    if ({D0_rd, D1_rd, out_valid} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: got %b expected 000", {D0_rd, D1_rd, out_valid});
    end
    tests_run++;
    if ({out_src, out_data} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out_word: got %h expected 0", {out_src, out_data});
    end
    tests_run++;
    if (cnt_D0 !== '0 || cnt_D1 !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", cnt_D0, cnt_D1);
    end
    tests_run++;
    if (state_out !== 2'd0 || idle_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_state_idle: got state %0d idle %b expected 0 1", state_out, idle_out);
    end
    reset = 1'b0;
    exp0.delete();
    exp1.delete();
    push0(6'h15);
    rd_seen = 0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (D0_rd || D1_rd || state_out != 2'd0 || out_valid) rd_seen++;
    end
    tests_run++;
    if (rd_seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL inactive_hold: got %0d bad cycles expected 0", rd_seen);
    end
    tests_run++;
    if (idle_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL inactive_idle: got %b expected 0 (D0 not empty)", idle_out);
    end
  endtask

  task automatic test_single_source();
    int base_rx;
    int base_rd;
    int n_rd0;
    int first;
    bit consec;
    do_reset();
    push0(6'h05);
    push0(6'h0A);
    base_rx = rx_q.size();
    base_rd = rd_hist.size();
    out_ready = 1'b1;
    active_in = 1'b1;
    for (int c = 0; c < 30 && rx_q.size() < base_rx + 2; c++) step(1);
    step(2);
    n_rd0 = 0;
    first = -1;
    for (int k = base_rd; k < rd_hist.size(); k++) begin
      if (rd_hist[k][0]) begin
        n_rd0++;
        if (first < 0) first = k;
      end
    end
    consec = (first >= 0) && (first + 1 < rd_hist.size()) && rd_hist[first + 1][0];
    tests_run++;
    if (n_rd0 !== 2 || consec !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_rd: got %0d reads consecutive=%b expected 2 reads consecutive=1", n_rd0, consec);
    end
    tests_run++;
    if (get_rx(base_rx) !== {1'b0, 6'h05} || get_rx(base_rx + 1) !== {1'b0, 6'h0A}) begin
      tests_failed++;
      $display("[TB] FAIL single_order: got %h %h expected 05 0a", get_rx(base_rx), get_rx(base_rx + 1));
    end
    tests_run++;
    if (cnt_D0 !== 8'd2 || cnt_D1 !== 8'd0 || idle_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_cnt_idle: got cnt %0d/%0d idle %b expected 2/0 1", cnt_D0, cnt_D1, idle_out);
    end
  endtask

  task automatic test_interleave();
    int base_rx;
    logic [BW:0] want [4];
    int bad;
    do_reset();
    push0(6'h01); push0(6'h02);
    push1(6'h31); push1(6'h32);
    want[0] = {1'b0, 6'h01}; want[1] = {1'b1, 6'h31};
    want[2] = {1'b0, 6'h02}; want[3] = {1'b1, 6'h32};
    base_rx = rx_q.size();
    out_ready = 1'b1;
    active_in = 1'b1;
    for (int c = 0; c < 30 && rx_q.size() < base_rx + 4; c++) step(1);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (get_rx(base_rx + k) !== want[k]) begin
        bad++;
        $display("[TB] FAIL interleave_word%0d: got %h expected %h", k, get_rx(base_rx + k), want[k]);
      end
    end
    tests_run++;
    if (bad != 0) tests_failed++;
    tests_run++;
    if (cnt_D0 !== 8'd2 || cnt_D1 !== 8'd2) begin
      tests_failed++;
      $display("[TB] FAIL interleave_cnt: got %0d/%0d expected 2/2", cnt_D0, cnt_D1);
    end
  endtask

  task automatic test_backpressure();
    int base_rx;
    int base_rd;
    int base_stab;
    int n_rd;
    int bad;
    do_reset();
    push0(6'h11); push0(6'h12);
    push1(6'h21); push1(6'h22);
    build_expect();
    base_rx = rx_q.size();
    base_rd = rd_hist.size();
    base_stab = stab_err;
    out_ready = 1'b0;
    active_in = 1'b1;
    step(10);
    n_rd = 0;
    for (int k = base_rd; k < rd_hist.size(); k++) if (rd_hist[k] != 2'b00) n_rd++;
    tests_run++;
    if (n_rd !== 2) begin
      tests_failed++;
      $display("[TB] FAIL stall_reads: got %0d expected 2", n_rd);
    end
    tests_run++;
    if (out_valid !== 1'b1 || {out_src, out_data} !== exp_q[0]) begin
      tests_failed++;
      $display("[TB] FAIL stall_head: got valid %b word %h expected 1 %h", out_valid, {out_src, out_data}, exp_q[0]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && rx_q.size() < base_rx + 4; c++) step(1);
    step(3);
    bad = 0;
    for (int k = 0; k < 4; k++) if (get_rx(base_rx + k) !== exp_q[k]) bad++;
    tests_run++;
    if (bad != 0 || rx_q.size() != base_rx + 4) begin
      tests_failed++;
      $display("[TB] FAIL stall_drain: got %0d wrong, %0d words expected 0 wrong, 4 words", bad, rx_q.size() - base_rx);
    end
    tests_run++;
    if (stab_err !== base_stab) begin
      tests_failed++;
      $display("[TB] FAIL stall_stable: got %0d changes expected 0", stab_err - base_stab);
    end
  endtask

  task automatic test_error();
    int base_rx;
    int base_rd;
    int base_bad;
    int after_err;
    int n_rd;
    int late_rd;
    int bad;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push0(BW'($urandom));
      push1(BW'($urandom));
    end
    build_expect();
    base_rx = rx_q.size();
    base_rd = rd_hist.size();
    base_bad = rd_bad;
    out_ready = 1'b1;
    active_in = 1'b1;
    step(4);
    error_in = 1'b1;
    step(1);
    error_in = 1'b0;
    after_err = rd_hist.size();
    tests_run++;
    if (state_out !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL error_enter: got state %0d expected 2", state_out);
    end
    step(12);
    n_rd = 0;
    late_rd = 0;
    for (int k = base_rd; k < rd_hist.size(); k++) begin
      if (rd_hist[k] != 2'b00) begin
        n_rd++;
        if (k >= after_err) late_rd++;
      end
    end
    tests_run++;
    if (late_rd !== 0 || rd_bad !== base_bad) begin
      tests_failed++;
      $display("[TB] FAIL error_no_reads: got %0d late reads expected 0", late_rd);
    end
    bad = 0;
    for (int k = 0; k < n_rd; k++) if (get_rx(base_rx + k) !== exp_q[k]) bad++;
    tests_run++;
    if (bad != 0 || rx_q.size() - base_rx != n_rd) begin
      tests_failed++;
      $display("[TB] FAIL error_drain: got %0d words %0d wrong expected %0d words 0 wrong", rx_q.size() - base_rx, bad, n_rd);
    end
    active_in = 1'b0;
    step(3);
    active_in = 1'b1;
    step(3);
    tests_run++;
    if (state_out !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL error_sticky: got state %0d expected 2", state_out);
    end
  endtask

  task automatic test_random();
    int base_rx;
    int base_both;
    int base_stab;
    int n0;
    int n1;
    int bad;
    for (int it = 0; it < 10; it++) begin
      do_reset();
      n0 = int'($urandom_range(0, 7));
      n1 = int'($urandom_range(0, 7));
      for (int k = 0; k < n0; k++) push0(BW'($urandom));
      for (int k = 0; k < n1; k++) push1(BW'($urandom));
      build_expect();
      base_rx = rx_q.size();
      base_both = both_rd;
      base_stab = stab_err;
      active_in = 1'b1;
      for (int c = 0; c < 200 && rx_q.size() < base_rx + n0 + n1; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        step(1);
      end
      out_ready = 1'b1;
      step(3);
      bad = 0;
      for (int k = 0; k < n0 + n1; k++) if (get_rx(base_rx + k) !== exp_q[k]) bad++;
      tests_run++;
      if (bad != 0 || rx_q.size() != base_rx + n0 + n1) begin
        tests_failed++;
        $display("[TB] FAIL random%0d_stream: got %0d words %0d wrong expected %0d words 0 wrong", it, rx_q.size() - base_rx, bad, n0 + n1);
      end
      tests_run++;
      if (cnt_D0 !== CNT_W'(n0) || cnt_D1 !== CNT_W'(n1) || idle_out !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL random%0d_cnt: got %0d/%0d idle %b expected %0d/%0d 1", it, cnt_D0, cnt_D1, idle_out, n0, n1);
      end
      tests_run++;
      if (both_rd !== base_both || stab_err !== base_stab) begin
        tests_failed++;
        $display("[TB] FAIL random%0d_protocol: got %0d dual reads %0d unstable expected 0 0", it, both_rd - base_both, stab_err - base_stab);
      end
    end
  endtask

  task automatic test_wrap();
    int base_rx;
    do_reset();
    for (int k = 0; k < (1 << CNT_W) + 1; k++) push1(BW'(k));
    base_rx = rx_q.size();
    out_ready = 1'b1;
    active_in = 1'b1;
    for (int c = 0; c < 400 && rx_q.size() < base_rx + (1 << CNT_W) + 1; c++) step(1);
    step(2);
    tests_run++;
    if (rx_q.size() - base_rx != (1 << CNT_W) + 1) begin
      tests_failed++;
      $display("[TB] FAIL wrap_words: got %0d expected %0d", rx_q.size() - base_rx, (1 << CNT_W) + 1);
    end
    tests_run++;
    if (cnt_D1 !== CNT_W'(1) || cnt_D0 !== '0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_cnt: got %0d/%0d expected 0/1", cnt_D0, cnt_D1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    active_in = 1'b0;
    error_in  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single_source();
    test_interleave();
    test_backpressure();
    test_error();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
